commit_trace_buffer: RTL and testbench

- Sits directly downstream of the single-cycle processor core, next to the data memory, and captures its architectural commit events: register-file writes and data-memory stores.
- Events are packed into records and buffered in a FIFO. A debug or host reader drains the FIFO over a valid/ready interface.
- Gives silicon and FPGA builds the same commit visibility the simulation bench gets by probing the register file and data-memory bus.

---
 rtl/riscv_trace_pkg.sv | 38 +++
 rtl/sync_fifo.sv | 62 ++++++
 rtl/commit_trace_buffer.sv | 119 +++++++++++
 tb/tb_commit_trace_buffer.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_trace_pkg.sv
// Shared definitions for the commit trace path: record kinds, field geometry
// and the packed record body that sits below the sequence number.
package riscv_trace_pkg;

  localparam int PC_W   = 32;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int KIND_W = 2;
  localparam int REC_W  = KIND_W + PC_W + ADDR_W + DATA_W;

  localparam int DATA_LSB = 0;
  localparam int ADDR_LSB = DATA_LSB + DATA_W;
  localparam int PC_LSB   = ADDR_LSB + ADDR_W;
  localparam int KIND_LSB = PC_LSB + PC_W;

  localparam logic [KIND_W-1:0] KIND_REG   = 2'b01;
  localparam logic [KIND_W-1:0] KIND_STORE = 2'b10;

  typedef struct packed {
    logic [KIND_W-1:0] kind;
    logic [PC_W-1:0]   pc;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } trace_rec_t;

  function automatic trace_rec_t pack_rec(input logic [KIND_W-1:0] kind,
                                          input logic [PC_W-1:0]   pc,
                                          input logic [ADDR_W-1:0] addr,
                                          input logic [DATA_W-1:0] data);
    trace_rec_t rec;
    rec.kind = kind;
    rec.pc   = pc;
    rec.addr = addr;
    rec.data = data;
    return rec;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock first-word-fall-through FIFO with wrap-bit pointers.
// A push into a full FIFO is accepted only when a pop frees a slot in the same cycle.
module sync_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clear,
  input  logic                   push,
  input  logic [WIDTH-1:0]       push_data,
  input  logic                   pop,
  output logic                   push_ok,
  output logic [WIDTH-1:0]       head_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wptr_q, wptr_d;
  logic [AW:0]      rptr_q, rptr_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic             pop_ok;

  assign empty     = (wptr_q == rptr_q);
  assign full      = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign level     = wptr_q - rptr_q;
  assign head_data = mem_q[rptr_q[AW-1:0]];

  // A pop on an empty FIFO is ignored, which also covers push-while-empty.
  assign pop_ok  = pop & ~empty & ~clear;
  assign push_ok = push & ~clear & (~full | pop_ok);

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    if (clear) begin
      wptr_d = '0;
      rptr_d = '0;
    end else begin
      if (push_ok) wptr_d = wptr_q + 1'b1;
      if (pop_ok)  rptr_d = rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/commit_trace_buffer.sv
// Captures register-file writes and data-memory stores from the core as
// sequence-numbered records and queues them for a valid/ready reader.
module commit_trace_buffer
  import riscv_trace_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter bit FILTER_X0 = 1'b1,
  parameter int SEQ_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     trace_en,
  input  logic                     clear,
  input  logic [31:0]              pc,
  input  logic                     rf_we,
  input  logic [4:0]               rf_addr,
  input  logic [31:0]              rf_wdata,
  input  logic                     mem_we,
  input  logic [31:0]              mem_addr,
  input  logic [31:0]              mem_wdata,
  output logic                     trace_valid,
  input  logic                     trace_ready,
  output logic [REC_W+SEQ_W-1:0]   trace_data,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow,
  output logic                     both_err,
  output logic [15:0]              drop_cnt
);

  logic                   reg_evt;
  logic                   store_evt;
  logic                   capture;
  logic                   push_req;
  logic                   push_ok;
  logic                   drop;
  logic                   fifo_full;
  logic                   fifo_empty;
  trace_rec_t             rec;
  logic [REC_W+SEQ_W-1:0] push_word;

  logic [SEQ_W-1:0] seq_q, seq_d;
  logic             overflow_q, overflow_d;
  logic             both_err_q, both_err_d;
  logic [15:0]      drop_cnt_q, drop_cnt_d;

  // A simultaneous store wins over the register write; both_err flags the collision.
  always_comb begin
    reg_evt   = rf_we & ~(FILTER_X0 & (rf_addr == 5'd0));
    store_evt = mem_we;
    capture   = trace_en & ~clear;
    push_req  = capture & (reg_evt | store_evt);
    if (store_evt) begin
      rec = pack_rec(KIND_STORE, pc, mem_addr, mem_wdata);
    end else begin
      rec = pack_rec(KIND_REG, pc, {27'd0, rf_addr}, rf_wdata);
    end
    push_word = {seq_q, rec};
  end

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W + SEQ_W)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .push      (push_req),
    .push_data (push_word),
    .pop       (trace_ready),
    .push_ok   (push_ok),
    .head_data (trace_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .level     (level)
  );

  assign drop = push_req & fifo_full & ~push_ok;

  // Dropped events leave seq untouched, so a gap is only visible through overflow.
  always_comb begin
    seq_d      = seq_q;
    overflow_d = overflow_q;
    both_err_d = both_err_q;
    drop_cnt_d = drop_cnt_q;
    if (clear) begin
      seq_d      = '0;
      overflow_d = 1'b0;
      both_err_d = 1'b0;
      drop_cnt_d = '0;
    end else begin
      if (push_ok) seq_d = seq_q + 1'b1;
      if (drop) begin
        overflow_d = 1'b1;
        if (drop_cnt_q != 16'hFFFF) drop_cnt_d = drop_cnt_q + 16'd1;
      end
      if (capture & reg_evt & store_evt) both_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      seq_q      <= '0;
      overflow_q <= 1'b0;
      both_err_q <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      seq_q      <= seq_d;
      overflow_q <= overflow_d;
      both_err_q <= both_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign trace_valid = ~fifo_empty;
  assign overflow    = overflow_q;
  assign both_err    = both_err_q;
  assign drop_cnt    = drop_cnt_q;

endmodule

// File: tb/tb_commit_trace_buffer.sv
// Directed and random checks of commit_trace_buffer against a queue-based
// reference model; a second instance with x0 filtering disabled covers that option.
module tb_commit_trace_buffer;

  localparam int DEPTH = 16;
  localparam int SEQ_W = 16;
  localparam int TW    = 98 + SEQ_W;

  logic          clk = 1'b0;
  logic          rst;
  logic          trace_en, clear, trace_ready;
  logic [31:0]   pc, rf_wdata, mem_addr, mem_wdata;
  logic          rf_we, mem_we;
  logic [4:0]    rf_addr;
  logic          trace_valid, overflow, both_err;
  logic [TW-1:0] trace_data;
  logic [4:0]    level;
  logic [15:0]   drop_cnt;

  logic          trace_en_b, trace_ready_b;
  logic          trace_valid_b, overflow_b, both_err_b;
  logic [TW-1:0] trace_data_b;
  logic [2:0]    level_b;
  logic [15:0]   drop_cnt_b;

  int n_assert = 0;
  int n_fail   = 0;

  logic [TW-1:0] mq[$];
  int            m_seq, m_dc;
  bit            m_ov, m_be;

  always #5 clk = ~clk;

  commit_trace_buffer #(.DEPTH(DEPTH), .FILTER_X0(1'b1), .SEQ_W(SEQ_W)) dut (
    .clk(clk), .rst(rst), .trace_en(trace_en), .clear(clear), .pc(pc),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .trace_valid(trace_valid), .trace_ready(trace_ready), .trace_data(trace_data),
    .level(level), .overflow(overflow), .both_err(both_err), .drop_cnt(drop_cnt)
  );

  commit_trace_buffer #(.DEPTH(4), .FILTER_X0(1'b0), .SEQ_W(SEQ_W)) dut_nofilt (
    .clk(clk), .rst(rst), .trace_en(trace_en_b), .clear(clear), .pc(pc),
    .rf_we(rf_we), .rf_addr(rf_addr), .rf_wdata(rf_wdata),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .trace_valid(trace_valid_b), .trace_ready(trace_ready_b), .trace_data(trace_data_b),
    .level(level_b), .overflow(overflow_b), .both_err(both_err_b), .drop_cnt(drop_cnt_b)
  );

  function automatic logic [TW-1:0] mk(input int seq, input logic [1:0] kind,
                                       input logic [31:0] p, input logic [31:0] a,
                                       input logic [31:0] d);
    logic [15:0] s;
    s = seq[15:0];
    return {s, kind, p, a, d};
  endfunction

  task automatic check_output(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_seq = 0;
    m_dc  = 0;
    m_ov  = 0;
    m_be  = 0;
  endtask

  // Reference behaviour for one clock edge, using the inputs currently driven.
  task automatic model_step();
    bit r, s;
    if (clear) begin
      model_reset();
    end else begin
      if (trace_ready && mq.size() > 0) void'(mq.pop_front());
      if (trace_en) begin
        r = rf_we && (rf_addr != 5'd0);
        s = mem_we;
        if (r && s) m_be = 1;
        if (r || s) begin
          if (mq.size() >= DEPTH) begin
            m_ov = 1;
            if (m_dc < 65535) m_dc++;
          end else begin
            if (s) mq.push_back(mk(m_seq, 2'b10, pc, mem_addr, mem_wdata));
            else   mq.push_back(mk(m_seq, 2'b01, pc, {27'd0, rf_addr}, rf_wdata));
            m_seq = (m_seq + 1) % 65536;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check_output("valid", trace_valid, mq.size() != 0);
    check_output("level", level, mq.size());
    check_output("overflow", overflow, m_ov);
    check_output("both_err", both_err, m_be);
    check_output("drop_cnt", drop_cnt, m_dc);
    if (mq.size() != 0) check_output("head", trace_data, mq[0]);
  endtask

  task automatic apply_stimulus();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic idle();
    trace_en = 1'b1; clear = 1'b0; trace_ready = 1'b0;
    rf_we = 1'b0; mem_we = 1'b0; rf_addr = 5'd0;
    rf_wdata = '0; mem_addr = '0; mem_wdata = '0;
  endtask

  task automatic reg_ev(input logic [31:0] p, input logic [4:0] a, input logic [31:0] d);
    pc = p; rf_we = 1'b1; rf_addr = a; rf_wdata = d; mem_we = 1'b0;
    apply_stimulus();
    rf_we = 1'b0;
  endtask

  initial begin
    rst = 1'b0;
    trace_en_b = 1'b0; trace_ready_b = 1'b0; pc = '0;
    idle();
    model_reset();
    #2;
    check_output("rst_valid", trace_valid, 1'b0);
    check_output("rst_level", level, 5'd0);
    check_output("rst_overflow", overflow, 1'b0);
    check_output("rst_drop_cnt", drop_cnt, 16'd0);
    #10 rst = 1'b1;
    apply_stimulus();

    $display("[TB] first records from reset");
    reg_ev(32'h00, 5'd6, 32'hB);
    check_output("first_rec", trace_data, mk(0, 2'b01, 32'h00, 32'd6, 32'hB));
    reg_ev(32'h04, 5'd7, 32'h5);
    reg_ev(32'h08, 5'd8, 32'h3);
    check_output("three_level", level, 5'd3);
    trace_ready = 1'b1;
    apply_stimulus();
    check_output("second_rec", trace_data, mk(1, 2'b01, 32'h04, 32'd7, 32'h5));
    apply_stimulus();
    check_output("third_rec", trace_data, mk(2, 2'b01, 32'h08, 32'd8, 32'h3));
    apply_stimulus();
    trace_ready = 1'b0;

    $display("[TB] branches, store, load, jal");
    pc = 32'h18; apply_stimulus();
    pc = 32'h20; apply_stimulus();
    check_output("branch_norec", level, 5'd0);
    pc = 32'h30; mem_we = 1'b1; mem_addr = 32'h9; mem_wdata = 32'h10;
    apply_stimulus();
    mem_we = 1'b0;
    check_output("store_rec", trace_data, mk(3, 2'b10, 32'h30, 32'h9, 32'h10));
    reg_ev(32'h34, 5'd15, 32'h10);
    reg_ev(32'h38, 5'd16, 32'h3C);
    trace_ready = 1'b1;
    apply_stimulus();
    check_output("load_rec", trace_data, mk(4, 2'b01, 32'h34, 32'd15, 32'h10));
    apply_stimulus();
    check_output("jal_rec", trace_data, mk(5, 2'b01, 32'h38, 32'd16, 32'h3C));
    apply_stimulus();
    trace_ready = 1'b0;

    $display("[TB] x0 filtering");
    trace_en_b = 1'b1;
    reg_ev(32'h40, 5'd0, 32'h77);
    trace_en_b = 1'b0;
    check_output("x0_filtered_level", level, 5'd0);
    check_output("x0_nofilt_valid", trace_valid_b, 1'b1);
    check_output("x0_nofilt_rec", trace_data_b, mk(0, 2'b01, 32'h40, 32'd0, 32'h77));

    $display("[TB] overflow and full push+pop");
    clear = 1'b1; apply_stimulus(); clear = 1'b0;
    for (int i = 0; i < 20; i++) reg_ev(32'h100 + 4 * i, 5'(i + 1), 32'(i));
    check_output("full_level", level, 5'd16);
    check_output("full_overflow", overflow, 1'b1);
    check_output("full_drop_cnt", drop_cnt, 16'd4);
    trace_ready = 1'b1;
    reg_ev(32'h200, 5'd9, 32'hAA);
    check_output("pushpop_level", level, 5'd16);
    check_output("pushpop_drop_cnt", drop_cnt, 16'd4);
    for (int i = 0; i < 16; i++) begin
      check_output("drain_seq", trace_data[TW-1:98], 16'(i + 1));
      apply_stimulus();
    end
    trace_ready = 1'b0;

    $display("[TB] both_err and clear");
    pc = 32'h300; rf_we = 1'b1; rf_addr = 5'd3; rf_wdata = 32'h1;
    mem_we = 1'b1; mem_addr = 32'h44; mem_wdata = 32'h55;
    apply_stimulus();
    idle();
    check_output("both_level", level, 5'd1);
    check_output("both_kind", trace_data[97:96], 2'b10);
    check_output("both_err", both_err, 1'b1);
    clear = 1'b1; reg_ev(32'h304, 5'd4, 32'h2); clear = 1'b0;
    check_output("clear_level", level, 5'd0);
    check_output("clear_both_err", both_err, 1'b0);
    check_output("clear_overflow", overflow, 1'b0);
    reg_ev(32'h308, 5'd5, 32'h3);
    check_output("clear_seq0", trace_data[TW-1:98], 16'd0);

    $display("[TB] asynchronous reset mid-burst");
    for (int i = 0; i < 4; i++) reg_ev(32'h400 + 4 * i, 5'd10, 32'(i));
    check_output("pre_rst_level", level, 5'd5);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_output("async_rst_valid", trace_valid, 1'b0);
    check_output("async_rst_level", level, 5'd0);
    #2 rst = 1'b1;
    reg_ev(32'h500, 5'd11, 32'h9);
    check_output("post_rst_seq0", trace_data[TW-1:98], 16'd0);

    $display("[TB] random traffic");
    for (int i = 0; i < 400; i++) begin
      pc          = $urandom;
      rf_we       = ($urandom_range(0, 99) < 60);
      rf_addr     = 5'($urandom_range(0, 31));
      rf_wdata    = $urandom;
      mem_we      = ($urandom_range(0, 99) < 25);
      mem_addr    = $urandom;
      mem_wdata   = $urandom;
      trace_en    = ($urandom_range(0, 99) < 90);
      trace_ready = ($urandom_range(0, 99) < 40);
      clear       = ($urandom_range(0, 99) < 2);
      if (rf_we && mem_we && rf_addr == 5'd0) rf_addr = 5'd1;
      apply_stimulus();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
